// File: rtl/umi_mem_tester.sv
// -----------------------------------------------------------------------------
// umi_mem_tester
//
// Host-side UMI initiator that exercises a UMI memory responder. A test first
// writes a pattern to every word of [base_addr, base_addr + count*DW/8) using
// acked writes. It then reads the same range back, checking each response for
// opcode, destination address and (for reads) data.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 one-cycle pulse that starts a test; ignored while busy
//   base_addr             first word address (DW/8 aligned)
//   count                 number of words; 0 gives an immediate done pulse
//   host_addr             srcaddr on requests, expected dstaddr on responses
//   busy, done            test in progress / one-cycle end-of-test pulse
//   err_count             saturating count of bad responses in the last test
//   uhost_req_*           UMI request port (valid/ready)
//   uhost_resp_*          UMI response port (valid/ready)
// -----------------------------------------------------------------------------
module umi_mem_tester #(
  parameter int          DW   = 128,
  parameter int          AW   = 64,
  parameter int          CW   = 32,
  parameter logic [31:0] SEED = 32'hA5A5_0000,
  parameter int          CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic [CNTW-1:0] count,
  input  logic [AW-1:0]   host_addr,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] err_count,
  output logic            uhost_req_valid,
  output logic [CW-1:0]   uhost_req_cmd,
  output logic [AW-1:0]   uhost_req_dstaddr,
  output logic [AW-1:0]   uhost_req_srcaddr,
  output logic [DW-1:0]   uhost_req_data,
  input  logic            uhost_req_ready,
  input  logic            uhost_resp_valid,
  input  logic [CW-1:0]   uhost_resp_cmd,
  input  logic [AW-1:0]   uhost_resp_dstaddr,
  input  logic [AW-1:0]   uhost_resp_srcaddr,
  input  logic [DW-1:0]   uhost_resp_data,
  output logic            uhost_resp_ready
);

  localparam logic [4:0]    OP_REQ_READ   = 5'h01;
  localparam logic [4:0]    OP_REQ_WRITE  = 5'h03;
  localparam logic [4:0]    OP_RESP_READ  = 5'h02;
  localparam logic [4:0]    OP_RESP_WRITE = 5'h04;
  localparam logic [2:0]    SIZE          = 3'($clog2(DW/8));
  localparam logic [CW-1:0] CMD_WR        = CW'({SIZE, OP_REQ_WRITE});
  localparam logic [CW-1:0] CMD_RD        = CW'({SIZE, OP_REQ_READ});
  localparam logic [AW-1:0] STEP          = AW'(DW/8);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RSP,
    RD_REQ,
    RD_RSP,
    FIN
  } state_t;

  state_t          state_reg, state_next;
  logic [CNTW-1:0] index_reg, index_next;
  logic [CNTW-1:0] count_reg, count_next;
  logic [CNTW-1:0] err_reg, err_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [AW-1:0]   base_reg, base_next;
  logic [AW-1:0]   host_reg, host_next;
  logic            zdone_reg, zdone_next;

  logic [31:0]     word_pat;
  logic [DW-1:0]   pattern;
  logic [CNTW-1:0] err_inc;
  logic            last_word;
  logic            unused_resp;

  // Source address of responses and the non-opcode command bits are not checked.
  assign unused_resp = ^{uhost_resp_srcaddr, uhost_resp_cmd[CW-1:5]};

  // Pattern of word i: SEED ^ i replicated across the data bus.
  assign word_pat = SEED ^ 32'(index_reg);
  generate
    for (genvar gi = 0; gi < DW/32; gi++) begin : g_pat
      assign pattern[gi*32 +: 32] = word_pat;
    end
  endgenerate

  assign err_inc   = (err_reg == {CNTW{1'b1}}) ? err_reg : err_reg + CNTW'(1);
  assign last_word = (index_reg == count_reg - CNTW'(1));
  assign err_count = err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      index_reg <= '0;
      count_reg <= '0;
      err_reg   <= '0;
      addr_reg  <= '0;
      base_reg  <= '0;
      host_reg  <= '0;
      zdone_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      count_reg <= count_next;
      err_reg   <= err_next;
      addr_reg  <= addr_next;
      base_reg  <= base_next;
      host_reg  <= host_next;
      zdone_reg <= zdone_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    index_next        = index_reg;
    count_next        = count_reg;
    err_next          = err_reg;
    addr_next         = addr_reg;
    base_next         = base_reg;
    host_next         = host_reg;
    zdone_next        = 1'b0;
    busy              = 1'b0;
    done              = zdone_reg;
    uhost_req_valid   = 1'b0;
    uhost_req_cmd     = '0;
    uhost_req_dstaddr = '0;
    uhost_req_srcaddr = '0;
    uhost_req_data    = '0;
    uhost_resp_ready  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          err_next = '0;
          if (count != '0) begin
            base_next  = base_addr;
            addr_next  = base_addr;
            count_next = count;
            host_next  = host_addr;
            index_next = '0;
            state_next = WR_REQ;
          end else begin
            // Empty test: report completion on the following cycle.
            zdone_next = 1'b1;
          end
        end
      end

      WR_REQ: begin
        busy              = 1'b1;
        uhost_req_valid   = 1'b1;
        uhost_req_cmd     = CMD_WR;
        uhost_req_dstaddr = addr_reg;
        uhost_req_srcaddr = host_reg;
        uhost_req_data    = pattern;
        if (uhost_req_ready) state_next = WR_RSP;
      end

      WR_RSP: begin
        busy             = 1'b1;
        uhost_resp_ready = 1'b1;
        if (uhost_resp_valid) begin
          if ((uhost_resp_cmd[4:0] != OP_RESP_WRITE) ||
              (uhost_resp_dstaddr != host_reg)) begin
            err_next = err_inc;
          end
          if (last_word) begin
            index_next = '0;
            addr_next  = base_reg;
            state_next = RD_REQ;
          end else begin
            index_next = index_reg + CNTW'(1);
            addr_next  = addr_reg + STEP;
            state_next = WR_REQ;
          end
        end
      end

      RD_REQ: begin
        busy              = 1'b1;
        uhost_req_valid   = 1'b1;
        uhost_req_cmd     = CMD_RD;
        uhost_req_dstaddr = addr_reg;
        uhost_req_srcaddr = host_reg;
        if (uhost_req_ready) state_next = RD_RSP;
      end

      RD_RSP: begin
        busy             = 1'b1;
        uhost_resp_ready = 1'b1;
        if (uhost_resp_valid) begin
          // Any combination of faults in one response counts once.
          if ((uhost_resp_cmd[4:0] != OP_RESP_READ) ||
              (uhost_resp_dstaddr != host_reg) ||
              (uhost_resp_data != pattern)) begin
            err_next = err_inc;
          end
          if (last_word) begin
            state_next = FIN;
          end else begin
            index_next = index_reg + CNTW'(1);
            addr_next  = addr_reg + STEP;
            state_next = RD_REQ;
          end
        end
      end

      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_umi_mem_tester.sv
// -----------------------------------------------------------------------------
// tb_umi_mem_tester
//
// Directed bench for umi_mem_tester. A behavioural single-outstanding memory
// responder answers requests, optionally with random stalls and injected
// faults, and independently checks request addresses, commands and data.
// -----------------------------------------------------------------------------
module tb_umi_mem_tester;

  logic          clk;
  logic          reset;
  logic          start;
  logic [63:0]   base_addr;
  logic [15:0]   count;
  logic [63:0]   host_addr;
  logic          busy;
  logic          done;
  logic [15:0]   err_count;
  logic          uhost_req_valid;
  logic [31:0]   uhost_req_cmd;
  logic [63:0]   uhost_req_dstaddr;
  logic [63:0]   uhost_req_srcaddr;
  logic [127:0]  uhost_req_data;
  logic          uhost_req_ready;
  logic          uhost_resp_valid;
  logic [31:0]   uhost_resp_cmd;
  logic [63:0]   uhost_resp_dstaddr;
  logic [63:0]   uhost_resp_srcaddr;
  logic [127:0]  uhost_resp_data;
  logic          uhost_resp_ready;

  int errors = 0;
  int checks = 0;

  // Responder knobs and expectations, written only by the stimulus process.
  bit          stall_mode = 1'b0;
  int          corrupt_rd = -1;
  int          bad_op_wr  = -1;
  int          bad_dst_wr = -1;
  logic [63:0] exp_base   = '0;
  logic [63:0] exp_host   = '0;

  // Responder / monitor state.
  logic [127:0] mem [0:255];
  int           wr_n;
  int           rd_n;
  logic         pend;
  logic [2:0]   dly;
  logic [2:0]   rnd_dly;
  int           proto_err = 0;
  int           stall_err = 0;
  int           req_cnt   = 0;
  int           done_cnt  = 0;
  logic         hold_v;
  logic [351:0] held;

  umi_mem_tester dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .base_addr          (base_addr),
    .count              (count),
    .host_addr          (host_addr),
    .busy               (busy),
    .done               (done),
    .err_count          (err_count),
    .uhost_req_valid    (uhost_req_valid),
    .uhost_req_cmd      (uhost_req_cmd),
    .uhost_req_dstaddr  (uhost_req_dstaddr),
    .uhost_req_srcaddr  (uhost_req_srcaddr),
    .uhost_req_data     (uhost_req_data),
    .uhost_req_ready    (uhost_req_ready),
    .uhost_resp_valid   (uhost_resp_valid),
    .uhost_resp_cmd     (uhost_resp_cmd),
    .uhost_resp_dstaddr (uhost_resp_dstaddr),
    .uhost_resp_srcaddr (uhost_resp_srcaddr),
    .uhost_resp_data    (uhost_resp_data),
    .uhost_resp_ready   (uhost_resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input int n);
    logic [31:0] w;
    w = 32'hA5A5_0000 ^ n[31:0];
    return {4{w}};
  endfunction

  // Memory responder: one response per accepted request, immediate unless
  // stalls are enabled.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      uhost_req_ready    <= 1'b0;
      uhost_resp_valid   <= 1'b0;
      uhost_resp_cmd     <= '0;
      uhost_resp_dstaddr <= '0;
      uhost_resp_srcaddr <= '0;
      uhost_resp_data    <= '0;
      pend               <= 1'b0;
      dly                <= '0;
      rnd_dly            <= '0;
      wr_n               <= 0;
      rd_n               <= 0;
    end else begin
      uhost_req_ready <= stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      rnd_dly         <= stall_mode ? 3'($urandom_range(0, 3)) : 3'd0;
      if (start && !busy) begin
        wr_n <= 0;
        rd_n <= 0;
      end
      if (uhost_resp_valid && uhost_resp_ready) uhost_resp_valid <= 1'b0;
      if (pend) begin
        if (dly == 3'd0) begin
          uhost_resp_valid <= 1'b1;
          pend             <= 1'b0;
        end else begin
          dly <= dly - 3'd1;
        end
      end
      if (uhost_req_valid && uhost_req_ready) begin
        if (rnd_dly == 3'd0) begin
          uhost_resp_valid <= 1'b1;
        end else begin
          pend <= 1'b1;
          dly  <= rnd_dly - 3'd1;
        end
        uhost_resp_srcaddr <= uhost_req_dstaddr;
        if (uhost_req_cmd[4:0] == 5'h03) begin
          if (uhost_req_dstaddr !== exp_base + 64'(wr_n) * 64'd16 ||
              uhost_req_cmd !== 32'h0000_0083 || uhost_req_srcaddr !== exp_host ||
              uhost_req_data !== pat(wr_n))
            proto_err <= proto_err + 1;
          mem[uhost_req_dstaddr[11:4]] <= uhost_req_data;
          uhost_resp_cmd     <= (wr_n == bad_op_wr) ? 32'h0000_0082 : 32'h0000_0084;
          uhost_resp_dstaddr <= (wr_n == bad_dst_wr) ? (uhost_req_srcaddr ^ 64'h1)
                                                     : uhost_req_srcaddr;
          uhost_resp_data    <= '0;
          wr_n <= wr_n + 1;
        end else if (uhost_req_cmd[4:0] == 5'h01) begin
          if (uhost_req_dstaddr !== exp_base + 64'(rd_n) * 64'd16 ||
              uhost_req_cmd !== 32'h0000_0081 || uhost_req_srcaddr !== exp_host ||
              uhost_req_data !== 128'h0)
            proto_err <= proto_err + 1;
          uhost_resp_cmd     <= 32'h0000_0082;
          uhost_resp_dstaddr <= uhost_req_srcaddr;
          uhost_resp_data    <= mem[uhost_req_dstaddr[11:4]] ^
                                ((rd_n == corrupt_rd) ? 128'h1 : 128'h0);
          rd_n <= rd_n + 1;
        end else begin
          proto_err <= proto_err + 1;
        end
      end
    end
  end

  // Request fields must hold while valid is stalled.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_v <= 1'b0;
      held   <= '0;
    end else begin
      if (hold_v && (!uhost_req_valid ||
          {uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr, uhost_req_data} !== held))
        stall_err <= stall_err + 1;
      hold_v <= uhost_req_valid && !uhost_req_ready;
      held   <= {uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr, uhost_req_data};
    end
  end

  always @(posedge clk) begin
    if (uhost_req_valid && uhost_req_ready) req_cnt <= req_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // Pulse start for one cycle; returns at the first negedge after the pulse.
  task automatic launch(input logic [63:0] b, input logic [15:0] c, input logic [63:0] h);
    @(negedge clk);
    exp_base  = b;
    exp_host  = h;
    base_addr = b;
    count     = c;
    host_addr = h;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // cyc = cycles since the start pulse at which done was seen.
  task automatic wait_done(input int limit, output int cyc, output bit ok);
    cyc = 1;
    ok  = 1'b0;
    while (cyc <= limit && !ok) begin
      if (done) ok = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    count = '0;
    host_addr = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, uhost_req_valid, uhost_resp_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, uhost_req_valid, uhost_resp_ready});
    end
    checks++;
    if (err_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_err: got %h expected 0000", err_count);
    end
    checks++;
    if ({uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr, uhost_req_data} !== 288'h0) begin
      errors++;
      $display("FAIL reset_req_fields: got nonzero cmd %h dst %h expected 0", uhost_req_cmd, uhost_req_dstaddr);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    $display("reset: released");
  endtask

  task automatic test_basic;
    int cyc, r0, d0;
    bit ok;
    r0 = req_cnt;
    d0 = done_cnt;
    launch(64'h1000, 16'd8, 64'h55);
    checks++;
    if ({uhost_req_valid, busy} !== 2'b11 || uhost_req_cmd !== 32'h83 ||
        uhost_req_dstaddr !== 64'h1000 || uhost_req_srcaddr !== 64'h55) begin
      errors++;
      $display("FAIL basic_first_req: got v=%b busy=%b cmd=%h dst=%h src=%h expected v=1 busy=1 cmd=83 dst=1000 src=55",
               uhost_req_valid, busy, uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr);
    end
    checks++;
    if (uhost_req_data !== 128'hA5A50000_A5A50000_A5A50000_A5A50000) begin
      errors++;
      $display("FAIL basic_first_data: got %h expected a5a50000 x4", uhost_req_data);
    end
    wait_done(200, cyc, ok);
    checks++;
    if (!ok || cyc != 33) begin
      errors++;
      $display("FAIL basic_latency: got done_seen=%0d cycles=%0d expected 1 and 33", ok, cyc);
    end
    checks++;
    if (busy !== 1'b0 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL basic_end_state: got busy=%b err=%0d expected 0 and 0", busy, err_count);
    end
    @(negedge clk);
    checks++;
    if (req_cnt - r0 != 16 || done_cnt - d0 != 1 || proto_err != 0) begin
      errors++;
      $display("FAIL basic_traffic: got reqs=%0d dones=%0d proto=%0d expected 16 1 0",
               req_cnt - r0, done_cnt - d0, proto_err);
    end
    $display("basic: base=1000 count=8 cycles=%0d err=%0d", cyc, err_count);
  endtask

  task automatic test_corrupt;
    int cyc;
    bit ok;
    corrupt_rd = 3;
    launch(64'h2000, 16'd8, 64'h55);
    wait_done(200, cyc, ok);
    checks++;
    if (!ok || err_count !== 16'd1) begin
      errors++;
      $display("FAIL corrupt_read: got done_seen=%0d err=%0d expected 1 and 1", ok, err_count);
    end
    corrupt_rd = -1;
    @(negedge clk);
    $display("corrupt: read word 3 flipped err=%0d", err_count);
  endtask

  task automatic test_zero_count;
    int r0;
    r0 = req_cnt;
    launch(64'h4000, 16'd0, 64'h55);
    checks++;
    if ({done, busy, uhost_req_valid} !== 3'b100 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL zero_count_done: got done=%b busy=%b valid=%b err=%0d expected 1 0 0 0",
               done, busy, uhost_req_valid, err_count);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || req_cnt != r0) begin
      errors++;
      $display("FAIL zero_count_after: got done=%b reqs=%0d expected 0 and 0", done, req_cnt - r0);
    end
    $display("zero_count: done pulse, no requests");
  endtask

  task automatic test_inject;
    int cyc;
    bit ok;
    bad_op_wr  = 1;
    bad_dst_wr = 5;
    launch(64'h2000, 16'd8, 64'h66);
    wait_done(200, cyc, ok);
    checks++;
    if (!ok || err_count !== 16'd2) begin
      errors++;
      $display("FAIL inject_write: got done_seen=%0d err=%0d expected 1 and 2", ok, err_count);
    end
    bad_op_wr  = -1;
    bad_dst_wr = -1;
    @(negedge clk);
    $display("inject: bad opcode w1, bad dstaddr w5 err=%0d", err_count);
  endtask

  task automatic test_wrap;
    int cyc;
    bit ok;
    launch(64'hFFFF_FFFF_FFFF_FFE0, 16'd4, 64'h9);
    wait_done(200, cyc, ok);
    checks++;
    if (!ok || err_count !== 16'd0 || proto_err != 0) begin
      errors++;
      $display("FAIL wrap_addr: got done_seen=%0d err=%0d proto=%0d expected 1 0 0", ok, err_count, proto_err);
    end
    @(negedge clk);
    $display("wrap: address wrap through zero err=%0d", err_count);
  endtask

  task automatic test_stall;
    int cyc, r0, d0;
    bit ok;
    r0 = req_cnt;
    d0 = done_cnt;
    stall_mode = 1'b1;
    launch(64'h0, 16'd64, 64'h77);
    repeat (20) @(negedge clk);
    // A second start while busy must change nothing.
    base_addr = 64'h8000;
    count     = 16'd5;
    host_addr = 64'h11;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5000, cyc, ok);
    checks++;
    if (!ok || err_count !== 16'd0) begin
      errors++;
      $display("FAIL stall_result: got done_seen=%0d err=%0d expected 1 and 0", ok, err_count);
    end
    @(negedge clk);
    stall_mode = 1'b0;
    checks++;
    if (req_cnt - r0 != 128 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL stall_count: got reqs=%0d dones=%0d expected 128 and 1", req_cnt - r0, done_cnt - d0);
    end
    checks++;
    if (stall_err != 0 || proto_err != 0) begin
      errors++;
      $display("FAIL stall_stable: got unstable=%0d proto=%0d expected 0 and 0", stall_err, proto_err);
    end
    repeat (4) @(negedge clk);
    $display("stall: count=64 reqs=%0d cycles=%0d", req_cnt - r0, cyc);
  endtask

  task automatic test_reset_abort;
    int cyc, n, d0;
    bit ok;
    launch(64'h3000, 16'd8, 64'h21);
    n = 0;
    while (rd_n != 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rd_n != 3 || uhost_resp_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_reach_rdrsp: got rd=%0d resp_ready=%b expected 3 and 1", rd_n, uhost_resp_ready);
    end
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, uhost_req_valid, uhost_resp_ready} !== 4'b0000 || err_count !== 16'd0 ||
        uhost_req_cmd !== 32'h0 || uhost_req_dstaddr !== 64'h0) begin
      errors++;
      $display("FAIL abort_in_reset: got busy=%b done=%b valid=%b rr=%b err=%0d expected all 0",
               busy, done, uhost_req_valid, uhost_resp_ready, err_count);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got dones=%0d busy=%b expected 0 and 0", done_cnt - d0, busy);
    end
    launch(64'h3000, 16'd4, 64'h21);
    wait_done(200, cyc, ok);
    checks++;
    if (!ok || err_count !== 16'd0 || proto_err != 0) begin
      errors++;
      $display("FAIL abort_rerun: got done_seen=%0d err=%0d proto=%0d expected 1 0 0", ok, err_count, proto_err);
    end
    @(negedge clk);
    $display("reset_abort: rerun count=4 cycles=%0d err=%0d", cyc, err_count);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corrupt();
    test_zero_count();
    test_inject();
    test_wrap();
    test_stall();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/umi_mem_tester.md
Name: umi_mem_tester

Overview:
- Host-side UMI initiator that exercises a UMI memory responder such as umi_mem_agent.
- Issues an acked write sweep over a word range, then a read-back sweep, and checks every response.
- Drives a UMI request port and consumes a UMI response port, either directly or through umi_fifo instances.
- Reports busy, done, and an error count for benches and for on-chip BIST.

Parameters:
- DW, 128, UMI data width in bits (multiple of 32, at least 32)
- AW, 64, UMI address width
- CW, 32, UMI command width
- SEED, 32'hA5A5_0000, 32-bit pattern seed
- CNTW, 16, width of the word-count and error-count fields

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- start  input  1  one-cycle pulse; starts a test; ignored while busy
- base_addr  input  AW  first word address; must be DW/8-aligned
- count  input  CNTW  number of words to test; 0 gives immediate done
- host_addr  input  AW  srcaddr placed on requests; expected as dstaddr on responses
- busy  output  1  test in progress
- done  output  1  one-cycle pulse at test end
- err_count  output  CNTW  mismatches seen in the last test; saturating
- uhost_req_valid  output  1  request valid
- uhost_req_cmd  output  CW  request command
- uhost_req_dstaddr  output  AW  request destination address
- uhost_req_srcaddr  output  AW  request source address
- uhost_req_data  output  DW  request data
- uhost_req_ready  input  1  request ready
- uhost_resp_valid  input  1  response valid
- uhost_resp_cmd  input  CW  response command
- uhost_resp_dstaddr  input  AW  response destination address
- uhost_resp_srcaddr  input  AW  response source address; not checked
- uhost_resp_data  input  DW  response data
- uhost_resp_ready  output  1  response ready

Behaviour:
- Reset (async, active-high):
  - busy=0, done=0, err_count=0, uhost_req_valid=0, uhost_resp_ready=0.
  - req cmd/addr/data = 0; FSM=IDLE; index=0.
  - Reset asserted mid-test aborts it immediately; no done pulse is produced.
- Command encoding, all other cmd bits 0:
  - opcode cmd[4:0]: REQ_READ=5'h01, REQ_WRITE=5'h03, RESP_READ=5'h02, RESP_WRITE=5'h04.
  - SIZE cmd[7:5] = log2(DW/8).
  - LEN cmd[15:8] = 0 (one word per transaction).
- Address of word i = base_addr + i*(DW/8), computed modulo 2^AW; wrap-around is permitted and not flagged.
- Pattern of word i: DW/32 copies of (SEED ^ i zero-extended to 32 bits).
- Handshake rules:
  - A transfer occurs on a cycle with valid & ready.
  - Once uhost_req_valid rises, valid and all req fields are held stable until accepted.
  - Exactly one transaction is outstanding at a time.
  - uhost_resp_ready is 1 only in the WR_RSP and RD_RSP states.
- FSM:
  - IDLE: on start & count!=0, latch base_addr/count/host_addr, index=0, err_count=0, busy=1, go to WR_REQ. On start & count==0, done=1 for one cycle, err_count=0, stay in IDLE.
  - WR_REQ: valid=1, opcode REQ_WRITE, data=pattern(index). On accept, go to WR_RSP.
  - WR_RSP: on response transfer, check opcode==RESP_WRITE and dstaddr==host_addr; each failing response adds +1. If index==count-1, set index=0 and go to RD_REQ; else index++ and go to WR_REQ.
  - RD_REQ: valid=1, opcode REQ_READ, data=0. On accept, go to RD_RSP.
  - RD_RSP: on response transfer, check opcode==RESP_READ, dstaddr==host_addr, and data==pattern(index); at most +1 per response. If last word, go to FIN; else index++ and go to RD_REQ.
  - FIN: busy=0, done=1 for one cycle, go to IDLE.
- err_count saturates at 2^CNTW-1.
- Timing:
  - Earliest request valid is the cycle after start.
  - Minimum time per word is 4 cycles when ready and responses are immediate.
- Response arriving in the same cycle the request is accepted: it is not consumed, since resp_ready=0 in *_REQ states; it is taken the next cycle.
- Unsolicited response while IDLE: it is not consumed (ready=0).
- start pulses while busy are ignored; latched inputs are not updated.

Test Plan:
- Loop through umi_mem_agent, base_addr=0x1000, count=8, host_addr=0x55:
  - -> 8 REQ_WRITE then 8 REQ_READ, addrs 0x1000..0x1070 step 0x10.
  - -> done pulses once, err_count=0, busy low after done.
- count=0 start:
  - -> done the next cycle, no request issued, err_count=0.
- Responder model corrupts word 3 read data (bit 0 flipped), count=8:
  - -> err_count=1.
- Wrong-opcode and wrong-dstaddr injection on words 1 and 5 of writes:
  - -> err_count=2.
- Random req_ready/resp_valid stalls (valid_mode/ready_mode 2) through two umi_fifo stages, count=64:
  - -> req fields stable while stalled, err_count=0, exactly 128 requests.
- Reset asserted in RD_RSP of word 2, then released, then start with count=4:
  - -> outputs at reset values during reset, no done for the aborted test, second test completes with err_count=0.
